intc_ctrl: RTL and testbench
============================

Name: intc_ctrl

Overview:
- Four-source interrupt controller between completion-pulse producers (done1..done4) and a processor core.
- Latches a completion event per source as a pending bit and raises irq.
- Presents the 32-bit handler address of the highest-priority pending source on PC_handler.
- Retires that source when the core acknowledges with iack.

Parameters:
- VEC1, 32'h0000_0100, handler address for source 1 (highest priority)
- VEC2, 32'h0000_0200, handler address for source 2
- VEC3, 32'h0000_0300, handler address for source 3
- VEC4, 32'h0000_0400, handler address for source 4 (lowest priority)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset (reset applied when rst==0 at a rising clk edge)
- done1  input  1  source 1 completion signal, level, edge-detected internally
- done2  input  1  source 2 completion signal
- done3  input  1  source 3 completion signal
- done4  input  1  source 4 completion signal
- iack  input  1  interrupt acknowledge from core, edge-detected internally
- PC_handler  output  32  handler address of the source currently being requested; 0 when idle
- irq  output  1  interrupt request to core

Behaviour:
- Reset (rst==0 at clk edge): pending[4:1]=0, done edge-history regs=0, iack history=0, state=IDLE, irq=0, PC_handler=32'h0.
- Event capture:
  - pending[n] sets on a rising edge of doneN, i.e. doneN==1 this cycle and 0 last sampled cycle.
  - A level held high sets pending once only.
  - A high level on the first cycle after reset counts as a rising edge.
- Acknowledge: iack is recognised only on its rising edge; holding iack high retires exactly one source.
- FSM (registered outputs), states IDLE, REQ:
  - IDLE: irq=0, PC_handler=0. If pending!=0, next state is REQ.
    - On that transition, latch sel = highest-priority pending source (1 > 2 > 3 > 4).
    - Also register irq=1 and PC_handler=VEC[sel], so both are valid one cycle after the pending bit is set.
  - REQ: irq=1, PC_handler=VEC[sel], both held stable.
    - A higher-priority source becoming pending does not preempt or change PC_handler.
  - REQ with iack rising edge: clear pending[sel], go to IDLE. irq=0 and PC_handler=0 from the next cycle.
- Re-arbitration:
  - After IDLE, any remaining pending source re-enters REQ on the following cycle.
  - irq therefore drops for at least one cycle between consecutive interrupts.
- Simultaneous events:
  - Rising edge on doneN in the same cycle pending[N] is cleared by ack: set wins, pending[N] stays 1 and re-requests.
  - Multiple done rising edges in one cycle: all pending bits set; served in priority order, one per ack.
- iack rising edge in IDLE is ignored; no pending bit changes.
- Reset in REQ: returns to IDLE with all pending cleared; irq drops on that edge.
- No queue depth beyond one event per source. Repeated events on a pending source before it is acked merge into one.

Test Plan:
- Reset: rst=0 for one edge, done*=x -> irq=0, PC_handler=0; hold rst=1 with all done low -> irq stays 0.
- All four sources: done1..4 pulse high together for one cycle -> next cycle irq=1, PC_handler=0x100. iack pulse -> irq=0 one cycle, then irq=1 with 0x200. Further acks give 0x300, then 0x400. After the fourth ack, irq=0 and PC_handler=0.
- Held levels: done2..4 held high continuously, done1=0 -> exactly three interrupts (0x200, 0x300, 0x400) over three acks; no re-trigger while held high.
- No preemption: in REQ for source 3 (0x300), pulse done1 -> PC_handler stays 0x300 until ack; next request shows 0x100.
- iack behaviour: iack held high for 3 cycles with two sources pending -> only one source retired. iack pulsed in IDLE -> no change.
- Set-wins collision: pulse done2 on the same cycle as the ack of source 2 -> irq reasserts with PC_handler=0x200.

Source files
------------

// File: rtl/intc_ctrl.sv
// Four-source interrupt controller: latches done-pulse edges as pending bits and requests the
// core with the highest-priority handler address, retiring one source per iack rising edge.
module intc_ctrl #(
   parameter logic [31:0] VEC1 = 32'h0000_0100,
   parameter logic [31:0] VEC2 = 32'h0000_0200,
   parameter logic [31:0] VEC3 = 32'h0000_0300,
   parameter logic [31:0] VEC4 = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        done1,
   input  logic        done2,
   input  logic        done3,
   input  logic        done4,
   input  logic        iack,
   output logic [31:0] PC_handler,
   output logic        irq
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_REQ  = 1'b1;

   logic [3:0]  done_now;
   logic [3:0]  done_q;
   logic [3:0]  done_rise;
   logic        iack_q;
   logic        iack_rise;
   logic [3:0]  pending_q, pending_d;
   logic [3:0]  clr;
   logic        state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [1:0]  prio_sel;
   logic        irq_q, irq_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] prio_vec;

   assign done_now  = {done4, done3, done2, done1};
   assign done_rise = done_now & ~done_q;
   assign iack_rise = iack & ~iack_q;

   // Fixed priority: bit 0 (source 1) highest.
   always_comb begin
      prio_sel = 2'd0;
      prio_vec = VEC1;
      if (pending_q[0]) begin
         prio_sel = 2'd0;
         prio_vec = VEC1;
      end else if (pending_q[1]) begin
         prio_sel = 2'd1;
         prio_vec = VEC2;
      end else if (pending_q[2]) begin
         prio_sel = 2'd2;
         prio_vec = VEC3;
      end else begin
         prio_sel = 2'd3;
         prio_vec = VEC4;
      end
   end

   always_comb begin
      clr = 4'b0000;
      if (state_q == ST_REQ && iack_rise) begin
         clr[sel_q] = 1'b1;
      end
      // A new edge in the same cycle as the clear keeps the bit set.
      pending_d = (pending_q & ~clr) | done_rise;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      irq_d   = irq_q;
      pc_d    = pc_q;
      unique case (state_q)
         ST_IDLE: begin
            irq_d = 1'b0;
            pc_d  = 32'h0;
            if (pending_q != 4'b0000) begin
               state_d = ST_REQ;
               sel_d   = prio_sel;
               irq_d   = 1'b1;
               pc_d    = prio_vec;
            end
         end
         ST_REQ: begin
            if (iack_rise) begin
               state_d = ST_IDLE;
               irq_d   = 1'b0;
               pc_d    = 32'h0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
            pc_d    = 32'h0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         done_q    <= 4'b0000;
         iack_q    <= 1'b0;
         pending_q <= 4'b0000;
         state_q   <= ST_IDLE;
         sel_q     <= 2'd0;
         irq_q     <= 1'b0;
         pc_q      <= 32'h0;
      end else begin
         done_q    <= done_now;
         iack_q    <= iack;
         pending_q <= pending_d;
         state_q   <= state_d;
         sel_q     <= sel_d;
         irq_q     <= irq_d;
         pc_q      <= pc_d;
      end
   end

   assign irq        = irq_q;
   assign PC_handler = pc_q;

endmodule

// File: tb/tb_intc_ctrl.sv
// Directed bench for intc_ctrl: hand-computed irq / PC_handler expectations after each clock.
module tb_intc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        done1, done2, done3, done4;
   logic        iack;
   logic [31:0] PC_handler;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   intc_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .done1      (done1),
      .done2      (done2),
      .done3      (done3),
      .done4      (done4),
      .iack       (iack),
      .PC_handler (PC_handler),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_done(input logic [3:0] d);
      {done4, done3, done2, done1} = d;
   endtask

   task automatic chk(input string tag, input logic irq_exp, input logic [31:0] pc_exp);
      n_checks++;
      assert (irq === irq_exp) else begin
         n_fail++;
         $error("FAIL %s irq observed=%b expected=%b", tag, irq, irq_exp);
      end
      n_checks++;
      assert (PC_handler === pc_exp) else begin
         n_fail++;
         $error("FAIL %s PC_handler observed=%h expected=%h", tag, PC_handler, pc_exp);
      end
   endtask

   // One iack pulse: edge with iack=1 retires, following edge with iack=0.
   task automatic ack_pulse(input string tag, input logic irq_exp, input logic [31:0] pc_exp);
      iack = 1'b1;
      step();
      chk({tag, "_ack"}, 1'b0, 32'h0);
      iack = 1'b0;
      step();
      chk({tag, "_next"}, irq_exp, pc_exp);
   endtask

   initial begin
      rst  = 1'b0;
      iack = 1'b0;
      set_done(4'bxxxx);
      step();
      chk("reset", 1'b0, 32'h0);
      set_done(4'b0000);
      step();
      rst = 1'b1;
      step();
      step();
      chk("idle_after_reset", 1'b0, 32'h0);

      // All four sources at once, served 1,2,3,4.
      set_done(4'b1111);
      step();
      set_done(4'b0000);
      chk("all_pend_edge", 1'b0, 32'h0);
      step();
      chk("all_src1", 1'b1, 32'h100);
      ack_pulse("all_a1", 1'b1, 32'h200);
      ack_pulse("all_a2", 1'b1, 32'h300);
      ack_pulse("all_a3", 1'b1, 32'h400);
      ack_pulse("all_a4", 1'b0, 32'h0);
      step();
      chk("all_done", 1'b0, 32'h0);

      // done2..4 held high: three interrupts only.
      set_done(4'b1110);
      step();
      step();
      chk("held_src2", 1'b1, 32'h200);
      ack_pulse("held_a1", 1'b1, 32'h300);
      ack_pulse("held_a2", 1'b1, 32'h400);
      ack_pulse("held_a3", 1'b0, 32'h0);
      step();
      step();
      chk("held_no_retrig", 1'b0, 32'h0);
      set_done(4'b0000);
      step();

      // No preemption while serving source 3.
      set_done(4'b0100);
      step();
      set_done(4'b0000);
      step();
      chk("nopre_src3", 1'b1, 32'h300);
      set_done(4'b0001);
      step();
      set_done(4'b0000);
      chk("nopre_hold1", 1'b1, 32'h300);
      step();
      chk("nopre_hold2", 1'b1, 32'h300);
      ack_pulse("nopre_a1", 1'b1, 32'h100);
      ack_pulse("nopre_a2", 1'b0, 32'h0);

      // iack held high retires one source only.
      set_done(4'b1100);
      step();
      set_done(4'b0000);
      step();
      chk("iackh_src3", 1'b1, 32'h300);
      iack = 1'b1;
      step();
      chk("iackh_retire", 1'b0, 32'h0);
      step();
      chk("iackh_src4", 1'b1, 32'h400);
      step();
      chk("iackh_src4_held", 1'b1, 32'h400);
      iack = 1'b0;
      step();
      chk("iackh_release", 1'b1, 32'h400);
      ack_pulse("iackh_a2", 1'b0, 32'h0);

      // iack in IDLE is ignored.
      iack = 1'b1;
      step();
      chk("idle_iack", 1'b0, 32'h0);
      iack = 1'b0;
      step();
      step();
      chk("idle_iack_after", 1'b0, 32'h0);

      // Set wins over ack clear for the same source.
      set_done(4'b0010);
      step();
      set_done(4'b0000);
      step();
      chk("sw_src2", 1'b1, 32'h200);
      set_done(4'b0010);
      iack = 1'b1;
      step();
      chk("sw_ack", 1'b0, 32'h0);
      set_done(4'b0000);
      iack = 1'b0;
      step();
      chk("sw_rereq", 1'b1, 32'h200);
      ack_pulse("sw_a2", 1'b0, 32'h0);

      // Reset while in REQ; done1 held high across reset counts as a fresh edge.
      set_done(4'b0101);
      step();
      step();
      chk("rreq_src1", 1'b1, 32'h100);
      set_done(4'b0001);
      rst = 1'b0;
      step();
      chk("rreq_reset", 1'b0, 32'h0);
      rst = 1'b1;
      step();
      chk("rreq_pend", 1'b0, 32'h0);
      step();
      chk("rreq_src1_again", 1'b1, 32'h100);
      set_done(4'b0000);
      ack_pulse("rreq_a1", 1'b0, 32'h0);
      step();
      chk("rreq_src3_cleared", 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
